sc_level_scheduler: RTL and testbench
=====================================

# sc_level_scheduler

Game-progress controller for the Road Fighter datapath. It sequences the game through idle, run, pause and game-over, and emits a one-cycle LOAD strobe that advances the road/obstacle shift registers at a level-dependent period. It also counts the level and drives the speed-tier select for the downstream mux. It sits between the board buttons/collision comparator and the shift-register/mux datapath.

## Interface
- TIMER_WIDTH, 25: width of the period down-counter.
- LEVEL_WIDTH, 8: width of the level counter.
- PERIOD_T0, 17500000: cycles between LOADs in tier 0 (0.35 s at 50 MHz).
- PERIOD_T1, 15000000: tier 1 period (0.30 s).
- PERIOD_T2, 12500000: tier 2 period (0.25 s).
- PERIOD_T3, 10000000: tier 3 period (0.20 s).
- TIER1_LEVEL, 11: first level of tier 1.
- TIER2_LEVEL, 33: first level of tier 2.
- TIER3_LEVEL, 60: first level of tier 3.
- LOADS_PER_LEVEL, 16: LOAD strobes per level increment.
- LEVEL_MAX, 99: saturation value of the level.
- SC_LEVELSCHED_CLOCK_50  in  1  system clock, 50 MHz.
- SC_LEVELSCHED_RESET_InHigh  in  1  reset, synchronous, active-high.
- SC_LEVELSCHED_START_InLow  in  1  debounced start button, active-low.
- SC_LEVELSCHED_COLLISION_InHigh  in  1  collision flag from the datapath comparator.
- SC_LEVELSCHED_LOAD_OutHigh  out  1  one-cycle shift/load strobe.
- SC_LEVELSCHED_CLEAR_OutHigh  out  1  one-cycle datapath clear strobe.
- SC_LEVELSCHED_LEVEL_Out  out  LEVEL_WIDTH  current level.
- SC_LEVELSCHED_TIER_Out  out  2  speed tier; mux select.
- SC_LEVELSCHED_STATE_Out  out  2  IDLE=0, RUN=1, PAUSE=2, GAMEOVER=3.
- SC_LEVELSCHED_GAMEOVER_OutHigh  out  1  high while in GAMEOVER.

## Operation
- **Start event:** a falling edge of START_InLow, detected with one register (reset value 1). A held-low button gives exactly one event.
- **IDLE:**
  - A start event moves the block to RUN.
  - On that transition, CLEAR pulses, level and load-count clear to 0, and the timer loads PERIOD_T0-1.
- **RUN:**
  - The timer decrements every cycle.
  - At 0, LOAD pulses and the timer reloads with (period of current tier)-1.
  - Each LOAD increments the load-count. On the LOADS_PER_LEVEL-th LOAD, load-count clears and level increments, saturating at LEVEL_MAX.
- **Tier:** combinational from the level register.
  - level<TIER1_LEVEL gives 0.
  - level<TIER2_LEVEL gives 1.
  - level<TIER3_LEVEL gives 2.
  - Otherwise 3.
  - The tier is sampled at each reload, so a tier change first affects the period after the current one.
- **Collision in RUN:** moves to GAMEOVER.
  - If it coincides with timer expiry, the collision wins: no LOAD, no level increment.
  - Level and timer freeze.
- **GAMEOVER:** collision is ignored. A start event moves to IDLE; level is held until the next RUN entry.
- **Start event in RUN:** behaviour depends on the configuration (see Configuration).
- **Reset:** overrides everything.
  - State IDLE; all outputs 0; level 0; load-count 0.
  - Timer reloads PERIOD_T0-1; start-edge register set to 1.
  - Reset asserted mid-RUN suppresses any LOAD in that cycle.

## Timing
- All outputs are registered except TIER, which is combinational from the level register.
- Start event in cycle n gives STATE=RUN and CLEAR=1 in cycle n+1. CLEAR is 0 from n+2.
- The first LOAD comes PERIOD_T0 cycles after CLEAR. After that, LOADs are spaced exactly by the tier period.
- Level updates in the cycle after its qualifying LOAD pulse.
- Collision sampled in cycle n gives STATE=GAMEOVER and GAMEOVER=1 in cycle n+1.
- Periods of 1 are legal: LOAD is high every cycle in RUN.

## Configuration
- Macro: SC_LEVELSCHED_PAUSE_EN.
- **Defined:**
  - A start event in RUN moves to PAUSE; the timer and load-count hold and no LOAD is issued.
  - Collision is ignored in PAUSE.
  - A start event in PAUSE returns to RUN with the remaining timer count preserved; no CLEAR is issued.
- **Undefined:** the PAUSE state is absent and start events in RUN are ignored.

## Structure
- Shared package sc_levelsched_pkg holds:
  - state encoding constants;
  - default period and tier-threshold constants;
  - the 2-bit tier width.
- Sub-module sc_levelsched_timer: a reloadable TIMER_WIDTH down-counter with enable, load and tick outputs.
- The FSM, edge detector, load-count, level and tier logic stay in the top module.

## Test plan
Bench parameters: PERIOD_T0..T3=4,3,2,1; TIER1/2/3_LEVEL=2,3,4; LOADS_PER_LEVEL=2; LEVEL_MAX=5.

- **Reset then idle:** reset, then 100 idle cycles -> STATE=0, LOAD, CLEAR and GAMEOVER always 0, LEVEL=0.
- **Start and first level:** START low for 10 cycles -> exactly one CLEAR pulse, STATE=1, LOAD every 4 cycles, LEVEL=1 after the 2nd LOAD.
- **Tier progression:** run to LEVEL=2 -> TIER=1 and spacing 3; LEVEL=4 -> TIER=3 and LOAD every cycle; LEVEL saturates at 5 while LOADs continue.
- **Collision wins and restart:**
  - COLLISION asserted in the timer-expiry cycle -> no LOAD, STATE=3, GAMEOVER=1, LEVEL frozen.
  - Start event -> STATE=0.
  - Start event again -> CLEAR, LEVEL=0.
- **Reset mid-RUN:** reset asserted in a LOAD-due cycle -> no LOAD; all outputs 0 next cycle; next start gives first LOAD 4 cycles after CLEAR.
- **Pause, with SC_LEVELSCHED_PAUSE_EN:**
  - Start event mid-period -> STATE=2, no LOADs for 50 cycles, collision ignored.
  - Start event -> STATE=1, next LOAD after the remaining count.
  - Without the macro -> the start event is ignored and STATE stays 1.

Source files
------------

// File: rtl/sc_levelsched_pkg.sv
// Shared state encoding, default periods and tier thresholds for the level scheduler.
package sc_levelsched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_PAUSE    = 2'd2,
      ST_GAMEOVER = 2'd3
   } state_t;

   localparam int unsigned TIER_W = 2;

   localparam int unsigned DEF_PERIOD_T0       = 17500000;
   localparam int unsigned DEF_PERIOD_T1       = 15000000;
   localparam int unsigned DEF_PERIOD_T2       = 12500000;
   localparam int unsigned DEF_PERIOD_T3       = 10000000;
   localparam int unsigned DEF_TIER1_LEVEL     = 11;
   localparam int unsigned DEF_TIER2_LEVEL     = 33;
   localparam int unsigned DEF_TIER3_LEVEL     = 60;
   localparam int unsigned DEF_LOADS_PER_LEVEL = 16;
   localparam int unsigned DEF_LEVEL_MAX       = 99;

endpackage

// File: rtl/sc_levelsched_timer.sv
// Reloadable down-counter; o_tick is high while the count sits at zero.
module sc_levelsched_timer #(
   parameter int unsigned       WIDTH     = 25,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_tick
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_count <= RESET_VAL;
      else if (i_load)
         r_count <= i_load_val;
      else if (i_en)
         r_count <= r_count - 1'b1;
   end

   assign o_tick = (r_count == '0);

endmodule

// File: rtl/sc_level_scheduler.sv
// Road Fighter game-progress FSM: LOAD strobe pacing, level counting and speed tier.
// Optional pause support is built when SC_LEVELSCHED_PAUSE_EN is defined.
module sc_level_scheduler
   import sc_levelsched_pkg::*;
#(
   parameter int unsigned TIMER_WIDTH     = 25,
   parameter int unsigned LEVEL_WIDTH     = 8,
   parameter int unsigned PERIOD_T0       = DEF_PERIOD_T0,
   parameter int unsigned PERIOD_T1       = DEF_PERIOD_T1,
   parameter int unsigned PERIOD_T2       = DEF_PERIOD_T2,
   parameter int unsigned PERIOD_T3       = DEF_PERIOD_T3,
   parameter int unsigned TIER1_LEVEL     = DEF_TIER1_LEVEL,
   parameter int unsigned TIER2_LEVEL     = DEF_TIER2_LEVEL,
   parameter int unsigned TIER3_LEVEL     = DEF_TIER3_LEVEL,
   parameter int unsigned LOADS_PER_LEVEL = DEF_LOADS_PER_LEVEL,
   parameter int unsigned LEVEL_MAX       = DEF_LEVEL_MAX
) (
   input  logic                   SC_LEVELSCHED_CLOCK_50,
   input  logic                   SC_LEVELSCHED_RESET_InHigh,
   input  logic                   SC_LEVELSCHED_START_InLow,
   input  logic                   SC_LEVELSCHED_COLLISION_InHigh,
   output logic                   SC_LEVELSCHED_LOAD_OutHigh,
   output logic                   SC_LEVELSCHED_CLEAR_OutHigh,
   output logic [LEVEL_WIDTH-1:0] SC_LEVELSCHED_LEVEL_Out,
   output logic [TIER_W-1:0]      SC_LEVELSCHED_TIER_Out,
   output logic [1:0]             SC_LEVELSCHED_STATE_Out,
   output logic                   SC_LEVELSCHED_GAMEOVER_OutHigh
);

   localparam int unsigned CNT_W = (LOADS_PER_LEVEL > 1) ? $clog2(LOADS_PER_LEVEL) : 1;

   state_t                 r_state, w_state_next;
   logic                   r_start_d, w_start_ev;
   logic                   r_load, r_clear, r_gameover;
   logic [LEVEL_WIDTH-1:0] r_level;
   logic [CNT_W-1:0]       r_lcnt;
   logic [TIER_W-1:0]      w_tier;
   logic [TIMER_WIDTH-1:0] w_reload_val;
   logic                   w_tick, w_timer_en, w_timer_load, w_load_fire, w_clear_fire;

   assign w_start_ev = r_start_d & ~SC_LEVELSCHED_START_InLow;

   always_comb begin
      if (r_level < LEVEL_WIDTH'(TIER1_LEVEL))
         w_tier = 2'd0;
      else if (r_level < LEVEL_WIDTH'(TIER2_LEVEL))
         w_tier = 2'd1;
      else if (r_level < LEVEL_WIDTH'(TIER3_LEVEL))
         w_tier = 2'd2;
      else
         w_tier = 2'd3;
   end

   always_ff @(posedge SC_LEVELSCHED_CLOCK_50) begin
      if (SC_LEVELSCHED_RESET_InHigh)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   // Collision is checked before expiry so a simultaneous hit suppresses the LOAD and reload.
   always_comb begin
      w_state_next = r_state;
      w_timer_en   = 1'b0;
      w_timer_load = 1'b0;
      w_load_fire  = 1'b0;
      w_clear_fire = 1'b0;
      case (w_tier)
         2'd0:    w_reload_val = TIMER_WIDTH'(PERIOD_T0 - 1);
         2'd1:    w_reload_val = TIMER_WIDTH'(PERIOD_T1 - 1);
         2'd2:    w_reload_val = TIMER_WIDTH'(PERIOD_T2 - 1);
         default: w_reload_val = TIMER_WIDTH'(PERIOD_T3 - 1);
      endcase
      case (r_state)
         ST_IDLE: begin
            if (w_start_ev) begin
               w_state_next = ST_RUN;
               w_timer_load = 1'b1;
               w_reload_val = TIMER_WIDTH'(PERIOD_T0 - 1);
               w_clear_fire = 1'b1;
            end
         end
         ST_RUN: begin
            if (SC_LEVELSCHED_COLLISION_InHigh)
               w_state_next = ST_GAMEOVER;
`ifdef SC_LEVELSCHED_PAUSE_EN
            else if (w_start_ev)
               w_state_next = ST_PAUSE;
`endif
            else if (w_tick) begin
               w_load_fire  = 1'b1;
               w_timer_load = 1'b1;
            end else
               w_timer_en = 1'b1;
         end
`ifdef SC_LEVELSCHED_PAUSE_EN
         ST_PAUSE: begin
            if (w_start_ev)
               w_state_next = ST_RUN;
         end
`endif
         ST_GAMEOVER: begin
            if (w_start_ev)
               w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge SC_LEVELSCHED_CLOCK_50) begin
      if (SC_LEVELSCHED_RESET_InHigh) begin
         r_start_d  <= 1'b1;
         r_load     <= 1'b0;
         r_clear    <= 1'b0;
         r_gameover <= 1'b0;
         r_level    <= '0;
         r_lcnt     <= '0;
      end else begin
         r_start_d  <= SC_LEVELSCHED_START_InLow;
         r_load     <= w_load_fire;
         r_clear    <= w_clear_fire;
         r_gameover <= (w_state_next == ST_GAMEOVER);
         if (w_clear_fire) begin
            r_level <= '0;
            r_lcnt  <= '0;
         end else if (r_load) begin
            if (r_lcnt == CNT_W'(LOADS_PER_LEVEL - 1)) begin
               r_lcnt <= '0;
               if (r_level != LEVEL_WIDTH'(LEVEL_MAX))
                  r_level <= r_level + 1'b1;
            end else
               r_lcnt <= r_lcnt + 1'b1;
         end
      end
   end

   sc_levelsched_timer #(
      .WIDTH     (TIMER_WIDTH),
      .RESET_VAL (TIMER_WIDTH'(PERIOD_T0 - 1))
   ) u_timer (
      .i_clk      (SC_LEVELSCHED_CLOCK_50),
      .i_rst      (SC_LEVELSCHED_RESET_InHigh),
      .i_en       (w_timer_en),
      .i_load     (w_timer_load),
      .i_load_val (w_reload_val),
      .o_tick     (w_tick)
   );

   assign SC_LEVELSCHED_LOAD_OutHigh     = r_load;
   assign SC_LEVELSCHED_CLEAR_OutHigh    = r_clear;
   assign SC_LEVELSCHED_LEVEL_Out        = r_level;
   assign SC_LEVELSCHED_TIER_Out         = w_tier;
   assign SC_LEVELSCHED_STATE_Out        = r_state;
   assign SC_LEVELSCHED_GAMEOVER_OutHigh = r_gameover;

endmodule

// File: tb/tb_sc_level_scheduler.sv
// Directed bench for sc_level_scheduler with short periods (4,3,2,1) and low tier thresholds.
module tb_sc_level_scheduler;

   logic       clk = 1'b0;
   logic       rst, start_n, col;
   logic       load, clear, gameover;
   logic [7:0] level;
   logic [1:0] tier, state;

   int checks = 0;
   int errors = 0;
   int g_loads = 0;
   int g_clears = 0;

   always #5 clk = ~clk;

   sc_level_scheduler #(
      .TIMER_WIDTH     (8),
      .LEVEL_WIDTH     (8),
      .PERIOD_T0       (4),
      .PERIOD_T1       (3),
      .PERIOD_T2       (2),
      .PERIOD_T3       (1),
      .TIER1_LEVEL     (2),
      .TIER2_LEVEL     (3),
      .TIER3_LEVEL     (4),
      .LOADS_PER_LEVEL (2),
      .LEVEL_MAX       (5)
   ) dut (
      .SC_LEVELSCHED_CLOCK_50         (clk),
      .SC_LEVELSCHED_RESET_InHigh     (rst),
      .SC_LEVELSCHED_START_InLow      (start_n),
      .SC_LEVELSCHED_COLLISION_InHigh (col),
      .SC_LEVELSCHED_LOAD_OutHigh     (load),
      .SC_LEVELSCHED_CLEAR_OutHigh    (clear),
      .SC_LEVELSCHED_LEVEL_Out        (level),
      .SC_LEVELSCHED_TIER_Out         (tier),
      .SC_LEVELSCHED_STATE_Out        (state),
      .SC_LEVELSCHED_GAMEOVER_OutHigh (gameover)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (clear === 1'b1) g_clears++;
      if (load === 1'b1) g_loads++;
   endtask

   // Steps until LOAD is seen; the returned step count is compared against exp.
   task automatic wait_load(input string tag, input int exp);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (load !== 1'b1 && n < 60);
      chk(tag, 32'(n), 32'(exp));
   endtask

   task automatic chk_outs(input string tag, input int st, input int ld, input int cl,
                           input int go, input int lv);
      chk({tag, "_state"}, 32'(state), 32'(st));
      chk({tag, "_load"}, 32'(load), 32'(ld));
      chk({tag, "_clear"}, 32'(clear), 32'(cl));
      chk({tag, "_gameover"}, 32'(gameover), 32'(go));
      chk({tag, "_level"}, 32'(level), 32'(lv));
   endtask

   initial begin
      int bad_idle, loads0;
      rst = 1'b1; start_n = 1'b1; col = 1'b0;
      step(); step();
      rst = 1'b0;
      chk_outs("reset", 0, 0, 0, 0, 0);
      chk("reset_tier", 32'(tier), 32'd0);

      bad_idle = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (state !== 2'd0 || load !== 1'b0 || clear !== 1'b0 || gameover !== 1'b0 || level !== 8'd0)
            bad_idle++;
      end
      chk("idle_100", 32'(bad_idle), 32'd0);

      // Run 1: start held low, level progression through all tiers
      g_clears = 0;
      start_n = 1'b0;
      step();
      chk_outs("start", 1, 0, 1, 0, 0);
      wait_load("load1_gap", 4);
      wait_load("load2_gap", 4);
      chk("load2_level", 32'(level), 32'd0);
      start_n = 1'b1;
      step();
      chk("lvl1", 32'(level), 32'd1);
      chk("lvl1_tier", 32'(tier), 32'd0);
      wait_load("load3_gap", 3);
      wait_load("load4_gap", 4);
      step();
      chk("lvl2", 32'(level), 32'd2);
      chk("lvl2_tier", 32'(tier), 32'd1);
      wait_load("load5_gap", 3);
      wait_load("load6_gap_t1", 3);
      step();
      chk("lvl3", 32'(level), 32'd3);
      chk("lvl3_tier", 32'(tier), 32'd2);
      wait_load("load7_gap", 2);
      wait_load("load8_gap_t2", 2);
      step();
      chk("lvl4", 32'(level), 32'd4);
      chk("lvl4_tier", 32'(tier), 32'd3);
      chk("lvl4_noload", 32'(load), 32'd0);
      wait_load("load9_gap", 1);
      wait_load("load10_gap_t3", 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_every_cycle", 32'(load), 32'd1);
      end
      chk("level_sat", 32'(level), 32'd5);
      chk("one_clear", 32'(g_clears), 32'd1);

      // Collision in an expiry cycle (period 1: timer is at zero now)
      col = 1'b1;
      step();
      chk_outs("col_expiry", 3, 0, 0, 1, 5);
      loads0 = g_loads;
      for (int i = 0; i < 6; i++) begin
         col = (i % 2 == 0);
         step();
      end
      col = 1'b0;
      chk("gameover_noload", 32'(g_loads - loads0), 32'd0);
      chk_outs("gameover_hold", 3, 0, 0, 1, 5);

      start_n = 1'b0;
      step();
      chk_outs("to_idle", 0, 0, 0, 0, 5);
      start_n = 1'b1;
      step();
      start_n = 1'b0;
      step();
      chk_outs("restart", 1, 0, 1, 0, 0);
      start_n = 1'b1;

      // Reset in a LOAD-due cycle
      wait_load("r2_load1", 4);
      step(); step(); step();
      chk("pre_rst_noload", 32'(load), 32'd0);
      rst = 1'b1;
      step();
      chk_outs("rst_mid_run", 0, 0, 0, 0, 0);
      rst = 1'b0;
      start_n = 1'b0;
      step();
      chk_outs("post_rst_start", 1, 0, 1, 0, 0);
      start_n = 1'b1;
      wait_load("post_rst_first_load", 4);

      // Collision exactly at expiry with level 1: LOAD and level change suppressed
      wait_load("r3_load2", 4);
      step();
      chk("r3_lvl1", 32'(level), 32'd1);
      step(); step();
      col = 1'b1;
      step();
      col = 1'b0;
      chk_outs("col_wins", 3, 0, 0, 1, 1);
      step(); step();
      chk_outs("col_frozen", 3, 0, 0, 1, 1);

      start_n = 1'b0;
      step();
      start_n = 1'b1;
      step();
      start_n = 1'b0;
      step();
      chk_outs("r4_start", 1, 0, 1, 0, 0);
      start_n = 1'b1;
      wait_load("r4_load1", 4);
      step();
      start_n = 1'b0;
      step();
`ifdef SC_LEVELSCHED_PAUSE_EN
      chk("pause_state", 32'(state), 32'd2);
      start_n = 1'b1;
      loads0 = g_loads;
      for (int i = 0; i < 50; i++) begin
         col = (i % 7 == 3);
         step();
      end
      col = 1'b0;
      chk("pause_noload", 32'(g_loads - loads0), 32'd0);
      chk("pause_col_ignored", 32'(state), 32'd2);
      start_n = 1'b0;
      step();
      chk_outs("resume", 1, 0, 0, 0, 0);
      start_n = 1'b1;
      wait_load("resume_remaining", 3);
`else
      chk("run_start_ignored", 32'(state), 32'd1);
      start_n = 1'b1;
      wait_load("run_start_no_effect", 2);
      chk("still_run", 32'(state), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
